adc_responder: RTL and testbench
================================

Name: adc_responder

Overview:
- Synthesizable emulator of the parallel 8-bit ADC that the timing manager drives. It answers CONVST/CS/RD with BUSY and a read data bus.
- Conversion results come from an internal test-pattern generator: ramp, triangle, square or constant.
- Sits on the FPGA in place of the real converter, so the acquisition path can be checked end-to-end without hardware.

Parameters:
- CONV_CYCLES, 40, Clk cycles BUSY stays high per conversion (min 2)
- RD_ACCESS, 2, Clk cycles from registered RD/CS low until DOe asserts (min 1)
- SQ_HALF, 16, conversions per half-period of the square pattern

Ports:
- Clk  in  1  system clock
- Rst  in  1  asynchronous active-low reset
- CS  in  1  chip select, active low, synchronous to Clk
- RD  in  1  read strobe, active low, synchronous to Clk
- CONVST  in  1  conversion start; rising edge starts a conversion
- Shape  in  2  pattern select: 0 ramp, 1 triangle, 2 square, 3 constant
- Step  in  8  pattern increment (ramp/triangle) or constant value
- DOut  out  8  read data
- DOe  out  1  DOut valid / bus-drive enable
- BUSY  out  1  conversion in progress
- Overrun  out  1  one-cycle pulse: CONVST edge ignored

Behaviour:
- Reset (Rst=0, any time, including mid-conversion or mid-read):
  - DOut=0, DOe=0, BUSY=0, Overrun=0.
  - State IDLE; result=0; pattern accumulator acc=0; triangle direction up; square level 0x00 with counter 0; conversion counter 0.
  - Input history registers (CONVST/CS/RD previous values) reset: CONVST to 0, CS and RD to 1.
- Input registering and edge detection:
  - CS, RD and CONVST are registered once.
  - Edges are detected by comparing each registered value with its previous registered value.
  - All reactions below are timed from the cycle the edge is detected.
- State machine:
  - IDLE: on CONVST rising edge, capture the pattern value into sample, go to CONVERT, BUSY=1 the next cycle, counter=CONV_CYCLES-1.
  - CONVERT: counter decrements each cycle. At 0: result<=sample, BUSY=0 the same edge, go to READY. BUSY is therefore high for exactly CONV_CYCLES cycles.
  - READY: a CONVST rising edge behaves as in IDLE. Completing a read (RD rising while registered CS=0) goes to IDLE.
  - A CONVST rising edge while in CONVERT is ignored: no restart, counter unchanged, Overrun=1 for one cycle.
- Pattern generator:
  - Advances once per accepted conversion start, after the sample is captured. All arithmetic is 8-bit.
  - Ramp: acc <= acc+Step, wraps mod 256 (0xF0+0x20=0x10).
  - Triangle, direction up: acc <= min(acc+Step, 255); reaching 255 flips to down.
  - Triangle, direction down: acc <= max(acc-Step, 0); reaching 0 flips to up.
  - Square: level toggles between 0x00 and 0xFF every SQ_HALF accepted conversions.
  - Constant: sample = Step; acc is unchanged.
  - Changing Shape takes effect at the next conversion start. acc is never cleared except by reset.
- Read:
  - Registered CS=0 and RD=0 held for RD_ACCESS consecutive cycles: DOe=1 and DOut=result.
  - DOe returns to 0 the cycle after either registered CS or RD goes high. DOut keeps its last value.
  - A read during CONVERT returns the previous result; the read is allowed and the state is unchanged.
  - A read with CS high is ignored: DOe stays 0.
- Simultaneous events:
  - CONVERT counter reaching 0 and a CONVST edge in the same cycle: the conversion completes, the edge is ignored and Overrun pulses.
  - Read completing in READY and a CONVST edge in the same cycle: the conversion starts (CONVERT wins over IDLE).
- Step=0 with ramp or triangle gives a constant output equal to acc.

Test Plan:
- Reset, Shape=0, Step=0x10, 4 x (CONVST pulse, wait BUSY low, CS/RD low 4 cycles) -> DOut 0x00,0x10,0x20,0x30; BUSY high exactly 40 cycles each; DOe rises RD_ACCESS cycles after registered RD low.
- Shape=1, Step=0x60, 6 conversions -> results 0x00,0x60,0xC0,0xFF,0x9F,0x3F.
- Second CONVST edge 10 cycles into a conversion -> Overrun one-cycle pulse; BUSY still falls 40 cycles after the first edge; only one pattern advance.
- Read during CONVERT -> DOut is the prior result. RD high -> DOe=0 the next registered cycle. RD low with CS high -> DOe stays 0.
- Shape=2, SQ_HALF=16, 40 conversions -> 16x 0x00, 16x 0xFF, 8x 0x00. Shape=3, Step=0xA5 -> every result 0xA5.
- Rst low mid-conversion and mid-read -> BUSY=0, DOe=0, DOut=0 immediately (asynchronous). The next ramp conversion with Step=0x10 returns 0x00.

Source files
------------

// File: rtl/adc_responder.sv
// rtl/adc_responder.sv - parallel 8-bit ADC emulator answering CONVST/CS/RD with BUSY and
// read data, sourcing conversion results from a ramp/triangle/square/constant pattern generator.
module adc_responder #(
  parameter int CONV_CYCLES = 40,
  parameter int RD_ACCESS   = 2,
  parameter int SQ_HALF     = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       CS,
  input  logic       RD,
  input  logic       CONVST,
  input  logic [1:0] Shape,
  input  logic [7:0] Step,
  output logic [7:0] DOut,
  output logic       DOe,
  output logic       BUSY,
  output logic       Overrun
);

  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam int RW = $clog2(RD_ACCESS + 1);
  localparam int SW = $clog2(SQ_HALF + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_READY} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      sample_q, sample_d;
  logic [7:0]      result_q, result_d;
  logic [7:0]      acc_q, acc_d;
  logic            dir_dn_q, dir_dn_d;
  logic            sq_lvl_q, sq_lvl_d;
  logic [SW-1:0]   sq_cnt_q, sq_cnt_d;
  logic [RW-1:0]   rd_cnt_q, rd_cnt_d;
  logic            doe_q, doe_d;
  logic [7:0]      dout_q, dout_d;
  logic            busy_q, busy_d;
  logic            ovr_q, ovr_d;
  logic            cs_r_q, rd_r_q, cv_r_q;
  logic            cs_p_q, rd_p_q, cv_p_q;

  logic            cv_rise, rd_done, rd_act, start;
  logic [7:0]      pat;
  logic [8:0]      sum9, diff9;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sample_q <= '0;
      result_q <= '0;
      acc_q    <= '0;
      dir_dn_q <= 1'b0;
      sq_lvl_q <= 1'b0;
      sq_cnt_q <= '0;
      rd_cnt_q <= '0;
      doe_q    <= 1'b0;
      dout_q   <= '0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      cs_r_q   <= 1'b1;
      rd_r_q   <= 1'b1;
      cv_r_q   <= 1'b0;
      cs_p_q   <= 1'b1;
      rd_p_q   <= 1'b1;
      cv_p_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      dir_dn_q <= dir_dn_d;
      sq_lvl_q <= sq_lvl_d;
      sq_cnt_q <= sq_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      doe_q    <= doe_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
      cs_r_q   <= CS;
      rd_r_q   <= RD;
      cv_r_q   <= CONVST;
      cs_p_q   <= cs_r_q;
      rd_p_q   <= rd_r_q;
      cv_p_q   <= cv_r_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sample_d = sample_q;
    result_d = result_q;
    acc_d    = acc_q;
    dir_dn_d = dir_dn_q;
    sq_lvl_d = sq_lvl_q;
    sq_cnt_d = sq_cnt_q;
    rd_cnt_d = '0;
    doe_d    = 1'b0;
    dout_d   = dout_q;
    busy_d   = busy_q;
    ovr_d    = 1'b0;
    start    = 1'b0;

    cv_rise = cv_r_q & ~cv_p_q;
    rd_done = rd_r_q & ~rd_p_q & ~cs_r_q;
    rd_act  = ~cs_r_q & ~rd_r_q;
    sum9    = {1'b0, acc_q} + {1'b0, Step};
    diff9   = {1'b0, acc_q} - {1'b0, Step};

    case (Shape)
      2'd2:    pat = {8{sq_lvl_q}};
      2'd3:    pat = Step;
      default: pat = acc_q;
    endcase

    case (state_q)
      S_IDLE: start = cv_rise;
      S_CONVERT: begin
        // Edges during a conversion, including its final cycle, are dropped.
        ovr_d = cv_rise;
        if (cnt_q == '0) begin
          result_d = sample_q;
          busy_d   = 1'b0;
          state_d  = S_READY;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_READY: begin
        if (cv_rise) start = 1'b1;
        else if (rd_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      sample_d = pat;
      state_d  = S_CONVERT;
      busy_d   = 1'b1;
      cnt_d    = CW'(CONV_CYCLES - 1);
      case (Shape)
        2'd0: acc_d = sum9[7:0];
        2'd1: begin
          if (!dir_dn_q) begin
            acc_d = sum9[8] ? 8'hFF : sum9[7:0];
            if (acc_d == 8'hFF) dir_dn_d = 1'b1;
          end else begin
            acc_d = diff9[8] ? 8'h00 : diff9[7:0];
            if (acc_d == 8'h00) dir_dn_d = 1'b0;
          end
        end
        2'd2: begin
          if (sq_cnt_q == SW'(SQ_HALF - 1)) begin
            sq_cnt_d = '0;
            sq_lvl_d = ~sq_lvl_q;
          end else begin
            sq_cnt_d = sq_cnt_q + SW'(1);
          end
        end
        default: ;
      endcase
    end

    if (rd_act) begin
      rd_cnt_d = (rd_cnt_q == RW'(RD_ACCESS)) ? rd_cnt_q : rd_cnt_q + RW'(1);
      doe_d    = (rd_cnt_q >= RW'(RD_ACCESS - 1));
      if (doe_d) dout_d = result_q;
    end
  end

  assign DOut    = dout_q;
  assign DOe     = doe_q;
  assign BUSY    = busy_q;
  assign Overrun = ovr_q;

endmodule

// File: tb/tb_adc_responder.sv
// tb/tb_adc_responder.sv - directed self-checking bench for adc_responder.
module tb_adc_responder;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       CS = 1'b1;
  logic       RD = 1'b1;
  logic       CONVST = 1'b0;
  logic [1:0] Shape = 2'd0;
  logic [7:0] Step = 8'h00;
  logic [7:0] DOut;
  logic       DOe;
  logic       BUSY;
  logic       Overrun;

  int         checks = 0;
  int         failures = 0;
  int         nb, no, doe_at;
  logic [7:0] rdata;
  logic [7:0] tri_exp [6];

  adc_responder #(.CONV_CYCLES(40), .RD_ACCESS(2), .SQ_HALF(16)) dut (
    .Clk(Clk), .Rst(Rst), .CS(CS), .RD(RD), .CONVST(CONVST),
    .Shape(Shape), .Step(Step), .DOut(DOut), .DOe(DOe),
    .BUSY(BUSY), .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Pulses CONVST, optionally again at cycle ov_at, and counts BUSY/Overrun cycles over 80 clocks.
  task automatic run_conv(input int ov_at, output int nbusy, output int novr);
    nbusy = 0;
    novr  = 0;
    @(negedge Clk) CONVST = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge Clk);
      if (BUSY) nbusy++;
      if (Overrun) novr++;
      if (i == 1 || i == ov_at + 1) CONVST = 1'b0;
      if (i == ov_at) CONVST = 1'b1;
    end
  endtask

  task automatic do_read(input logic cs_v, output logic [7:0] d, output int at);
    at = 0;
    d  = 8'h00;
    @(negedge Clk) begin CS = cs_v; RD = 1'b0; end
    for (int i = 1; i <= 4; i++) begin
      @(negedge Clk);
      if (DOe && at == 0) begin at = i; d = DOut; end
    end
    CS = 1'b1;
    RD = 1'b1;
    @(negedge Clk);
    check("doe_hold", 32'(DOe), cs_v ? 32'd0 : 32'd1);
    @(negedge Clk);
    check("doe_fall", 32'(DOe), 32'd0);
  endtask

  initial begin
    tri_exp = '{8'h00, 8'h60, 8'hC0, 8'hFF, 8'h9F, 8'h3F};
    repeat (3) @(negedge Clk);
    check("rst_dout", 32'(DOut), 32'd0);
    check("rst_doe", 32'(DOe), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_ovr", 32'(Overrun), 32'd0);
    @(negedge Clk) Rst = 1'b1;

    Shape = 2'd0;
    Step  = 8'h10;
    for (int k = 0; k < 4; k++) begin
      run_conv(0, nb, no);
      check("ramp_busy_len", nb, 40);
      check("ramp_ovr", no, 0);
      do_read(1'b0, rdata, doe_at);
      check("ramp_data", 32'(rdata), 32'(k * 16));
      check("doe_latency", doe_at, 3);
    end

    run_conv(10, nb, no);
    check("ovr_busy_len", nb, 40);
    check("ovr_pulses", no, 1);
    do_read(1'b0, rdata, doe_at);
    check("ovr_data", 32'(rdata), 32'h40);
    run_conv(0, nb, no);
    do_read(1'b0, rdata, doe_at);
    check("ovr_single_adv", 32'(rdata), 32'h50);

    @(negedge Clk) CONVST = 1'b1;
    @(negedge Clk) CONVST = 1'b0;
    do_read(1'b0, rdata, doe_at);
    check("read_in_conv", 32'(rdata), 32'h50);
    check("busy_during_read", 32'(BUSY), 32'd1);
    for (int i = 0; i < 60 && BUSY; i++) @(negedge Clk);
    check("busy_done", 32'(BUSY), 32'd0);
    do_read(1'b0, rdata, doe_at);
    check("read_after_conv", 32'(rdata), 32'h60);
    do_read(1'b1, rdata, doe_at);
    check("cs_high_no_doe", doe_at, 0);

    @(negedge Clk) Rst = 1'b0;
    @(negedge Clk) Rst = 1'b1;
    Shape = 2'd1;
    Step  = 8'h60;
    for (int k = 0; k < 6; k++) begin
      run_conv(0, nb, no);
      do_read(1'b0, rdata, doe_at);
      check("triangle", 32'(rdata), 32'(tri_exp[k]));
    end

    Shape = 2'd2;
    for (int k = 0; k < 40; k++) begin
      run_conv(0, nb, no);
      do_read(1'b0, rdata, doe_at);
      check("square", 32'(rdata), (k >= 16 && k < 32) ? 32'hFF : 32'h00);
    end

    Shape = 2'd3;
    Step  = 8'hA5;
    for (int k = 0; k < 3; k++) begin
      run_conv(0, nb, no);
      do_read(1'b0, rdata, doe_at);
      check("constant", 32'(rdata), 32'hA5);
    end

    Shape = 2'd0;
    Step  = 8'h10;
    @(negedge Clk) CONVST = 1'b1;
    @(negedge Clk) CONVST = 1'b0;
    repeat (5) @(negedge Clk);
    check("mid_conv_busy", 32'(BUSY), 32'd1);
    check("pre_rst_dout", 32'(DOut), 32'hA5);
    #2 Rst = 1'b0;
    #1;
    check("rst_conv_busy", 32'(BUSY), 32'd0);
    check("rst_conv_dout", 32'(DOut), 32'd0);
    @(negedge Clk) Rst = 1'b1;

    run_conv(0, nb, no);
    run_conv(0, nb, no);
    @(negedge Clk) begin CS = 1'b0; RD = 1'b0; end
    repeat (3) @(negedge Clk);
    check("mid_read_doe", 32'(DOe), 32'd1);
    check("mid_read_dout", 32'(DOut), 32'h10);
    #2 Rst = 1'b0;
    #1;
    check("rst_read_doe", 32'(DOe), 32'd0);
    check("rst_read_dout", 32'(DOut), 32'd0);
    check("rst_read_busy", 32'(BUSY), 32'd0);
    CS = 1'b1;
    RD = 1'b1;
    @(negedge Clk) Rst = 1'b1;
    run_conv(0, nb, no);
    check("post_rst_busy_len", nb, 40);
    do_read(1'b0, rdata, doe_at);
    check("post_rst_ramp", 32'(rdata), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
